// File: rtl/paced_stream_mux.sv
// Multi-channel paced sampler: each channel captures its input every interval+1
// enabled cycles into a one-entry slot; a round-robin arbiter drains slots onto one stream.
module paced_stream_mux #(
  parameter int DW  = 32,
  parameter int NCH = 4,
  parameter int CW  = 8,
  parameter int IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH*CW-1:0] interval,
  input  logic [NCH*DW-1:0] data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  output logic [IDW-1:0]    m_chan,
  output logic [NCH-1:0]    ovf,
  input  logic [NCH-1:0]    ovf_clr
);

  logic [CW-1:0]  r_cnt  [NCH];
  logic [DW-1:0]  r_slot [NCH];
  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] r_ovf;
  logic [IDW-1:0] r_ptr;
  logic           r_m_valid;
  logic [DW-1:0]  r_m_data;
  logic [IDW-1:0] r_m_chan;

  logic           w_load;
  logic           w_found;
  logic [IDW-1:0] w_gnt;
  logic [IDW-1:0] w_ptr_nxt;
  logic [NCH-1:0] w_gnt_oh;
  logic [NCH-1:0] w_try;
  logic [NCH-1:0] w_cap;
  logic [NCH-1:0] w_ovr;

  // Round-robin grant: first pending channel at or after the pointer, wrapping.
  always_comb begin
    int idx;
    w_load    = (!r_m_valid || m_ready) && (|r_pend);
    w_found   = 1'b0;
    w_gnt     = IDW'(0);
    for (int k = 0; k < NCH; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NCH) begin
        idx = idx - NCH;
      end else begin
        idx = idx;
      end
      if (!w_found && r_pend[idx]) begin
        w_found = 1'b1;
        w_gnt   = IDW'(idx);
      end else begin
        w_found = w_found;
      end
    end
    if (int'(w_gnt) == NCH - 1) begin
      w_ptr_nxt = IDW'(0);
    end else begin
      w_ptr_nxt = w_gnt + IDW'(1);
    end
    if (w_load) begin
      w_gnt_oh = NCH'(1) << w_gnt;
    end else begin
      w_gnt_oh = NCH'(0);
    end
  end

  // Capture attempts; a slot being granted this cycle counts as free.
  always_comb begin
    w_try = NCH'(0);
    w_cap = NCH'(0);
    w_ovr = NCH'(0);
    for (int i = 0; i < NCH; i++) begin
      w_try[i] = en && (r_cnt[i] >= interval[i*CW +: CW]);
      w_cap[i] = w_try[i] && (!r_pend[i] || w_gnt_oh[i]);
      w_ovr[i] = w_try[i] && !w_cap[i];
    end
  end

  // Per-channel pacing counter, holding slot, pending and sticky overrun bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i]  <= CW'(0);
        r_slot[i] <= DW'(0);
      end
      r_pend <= NCH'(0);
      r_ovf  <= NCH'(0);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_cap[i]) begin
          r_cnt[i]  <= CW'(0);
          r_slot[i] <= data[i*DW +: DW];
          r_pend[i] <= 1'b1;
        end else begin
          if (en && !w_try[i]) begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end else begin
            r_cnt[i] <= r_cnt[i];
          end
          r_slot[i] <= r_slot[i];
          r_pend[i] <= r_pend[i] && !w_gnt_oh[i];
        end
        if (w_ovr[i]) begin
          r_ovf[i] <= 1'b1;
        end else if (ovf_clr[i]) begin
          r_ovf[i] <= 1'b0;
        end else begin
          r_ovf[i] <= r_ovf[i];
        end
      end
    end
  end

  // Registered output stage and arbiter pointer; drains regardless of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= DW'(0);
      r_m_chan  <= IDW'(0);
      r_ptr     <= IDW'(0);
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_data  <= r_slot[w_gnt];
      r_m_chan  <= w_gnt;
      r_ptr     <= w_ptr_nxt;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end else begin
      r_m_valid <= r_m_valid;
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_chan  = r_m_chan;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_paced_stream_mux.sv
// Randomized and directed bench for paced_stream_mux against a cycle-level reference model.
module tb_paced_stream_mux;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int IDW = 2;

  logic              clk;
  logic              rst;
  logic              en;
  logic [NCH*CW-1:0] interval;
  logic [NCH*DW-1:0] data;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic [IDW-1:0]    m_chan;
  logic [NCH-1:0]    ovf;
  logic [NCH-1:0]    ovf_clr;

  paced_stream_mux #(.DW(DW), .NCH(NCH), .CW(CW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .en(en), .interval(interval), .data(data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          mcnt  [NCH];
  logic [DW-1:0] mslot [NCH];
  bit          mpend [NCH];
  logic [NCH-1:0] movf;
  int          mptr;
  bit          mval;
  logic [DW-1:0] mdat;
  int          mch;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mcnt[i] = 0; mslot[i] = '0; mpend[i] = 0;
    end
    movf = '0; mptr = 0; mval = 0; mdat = '0; mch = 0;
  endtask

  function automatic void set_iv(input int ch, input int v);
    interval[ch*CW +: CW] = CW'(v);
  endfunction

  function automatic void set_dat(input int ch, input logic [DW-1:0] v);
    data[ch*DW +: DW] = v;
  endfunction

  // One clock: advance the model with the current inputs, then compare at negedge.
  task automatic step();
    bit any_p;
    int g;
    any_p = 0;
    for (int i = 0; i < NCH; i++) any_p |= mpend[i];
    g = -1;
    if ((!mval || m_ready) && any_p) begin
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (mptr + k) % NCH;
        if (g < 0 && mpend[c]) g = c;
      end
      mdat = mslot[g]; mch = g; mval = 1; mptr = (g + 1) % NCH;
    end else if (mval && m_ready) begin
      mval = 0;
    end
    for (int i = 0; i < NCH; i++) begin
      int iv;
      bit ovr;
      iv  = int'(interval[i*CW +: CW]);
      ovr = 0;
      if (en && mcnt[i] >= iv) begin
        if (!mpend[i] || g == i) begin
          mslot[i] = data[i*DW +: DW]; mpend[i] = 1; mcnt[i] = 0;
        end else begin
          ovr = 1;
        end
      end else begin
        if (en) mcnt[i] = mcnt[i] + 1;
        if (g == i) mpend[i] = 0;
      end
      if (ovr) movf[i] = 1'b1;
      else if (ovf_clr[i]) movf[i] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_val("valid", 64'(m_valid), 64'(mval));
    check_val("data", 64'(m_data), 64'(mdat));
    check_val("chan", 64'(m_chan), 64'(mch));
    check_val("ovf", 64'(ovf), 64'(movf));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_val("rst_valid", 64'(m_valid), 64'd0);
    check_val("rst_data", 64'(m_data), 64'd0);
    check_val("rst_ovf", 64'(ovf), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] prev;
    logic [DW-1:0] d;
    logic [DW-1:0] xw;
    logic [DW-1:0] yw;
    int exp_ord [4];
    rst = 1'b0; en = 1'b0; m_ready = 1'b0; ovf_clr = '0;
    interval = '0; data = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // all intervals 3: one word per channel every 4 cycles, chan 0,1,2,3
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      set_iv(i, 3); set_dat(i, DW'(32'hA0 + i));
    end
    for (int c = 1; c <= 24; c++) begin
      step();
      if (c >= 5) begin
        check_val("s1_valid", 64'(m_valid), 64'd1);
        check_val("s1_chan", 64'(m_chan), 64'((c - 5) % 4));
        check_val("s1_data", 64'(m_data), 64'(32'hA0 + ((c - 5) % 4)));
      end
    end
    check_val("s1_ovf", 64'(ovf), 64'd0);

    // channel 2 alone, interval 0, output stalled
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < NCH; i++) set_iv(i, 255);
    set_iv(2, 0);
    xw = 32'h1234_5678; yw = 32'h9ABC_DEF0;
    set_dat(2, xw); step();
    set_dat(2, yw); step();
    step(); step();
    check_val("s2_held", 64'(m_data), 64'(xw));
    check_val("s2_ovf", 64'(ovf), 64'b0100);
    set_dat(2, 32'h5555_AAAA);
    m_ready = 1'b1; step();
    check_val("s2_next", 64'(m_data), 64'(yw));
    check_val("s2_chan", 64'(m_chan), 64'd2);

    // channel 1 captured and granted in the same cycle, back-to-back
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < NCH; i++) set_iv(i, 255);
    set_iv(1, 0);
    prev = '0;
    for (int c = 1; c <= 10; c++) begin
      d = $urandom;
      set_dat(1, d);
      step();
      if (c >= 2) check_val("s4_track", 64'(m_data), 64'(prev));
      prev = d;
    end
    check_val("s4_ovf", 64'(ovf[1]), 64'd0);

    // overrun clear versus same-cycle overrun
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < NCH; i++) set_iv(i, 255);
    set_iv(0, 0);
    repeat (4) step();
    check_val("s5_set", 64'(ovf[0]), 64'd1);
    en = 1'b0; ovf_clr = 4'b0001; step();
    check_val("s5_clr", 64'(ovf[0]), 64'd0);
    ovf_clr = 4'b0000; en = 1'b1; step();
    ovf_clr = 4'b0001; step();
    check_val("s5_prio", 64'(ovf[0]), 64'd1);
    ovf_clr = 4'b0000;

    // pointer at 2 with all channels pending: grant order 2,3,0,1
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      set_iv(i, 255); set_dat(i, DW'(32'hC0 + i));
    end
    set_iv(1, 0);
    step(); step();
    for (int i = 0; i < NCH; i++) set_iv(i, 0);
    step(); step();
    exp_ord = '{2, 3, 0, 1};
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("s3_order", 64'(m_chan), 64'(exp_ord[k]));
    end

    // reset mid-transfer with pending slots, then idle with en=0
    m_ready = 1'b0;
    step();
    check_val("s6_pre", 64'(m_valid), 64'd1);
    do_reset();
    en = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check_val("s6_idle", 64'(m_valid), 64'd0);
    end

    // randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 25 == 0) begin
        for (int i = 0; i < NCH; i++) set_iv(i, $urandom_range(0, 6));
      end
      for (int i = 0; i < NCH; i++) set_dat(i, DW'($urandom));
      en      = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
